// File: rtl/lc3b_types.sv
// lc3b_types: shared word, cache-line and icache FSM state types.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef enum logic {IDLE, FILL} icache_state_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: per-set valid/tag/line storage in flops with combinational read.
module icache_array
  import lc3b_types::*;
#(
  parameter int SETS = 8,
  parameter int INDEX_W = $clog2(SETS),
  parameter int TAG_W = 12 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  input  logic               we,
  input  logic [TAG_W-1:0]   wtag,
  input  lc3b_cacheline      wline,
  input  logic               inv_all,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output lc3b_cacheline      line
);
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tags [SETS];
  lc3b_cacheline lines [SETS];
  always_ff @(posedge clk) begin
    if (!rst_n || inv_all) valid_q <= '0;
    else if (we) valid_q[index] <= 1'b1;
  end
  // tag and data arrays are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      tags[index] <= wtag;
      lines[index] <= wline;
    end
  end
  assign valid = valid_q[index];
  assign tag = tags[index];
  assign line = lines[index];
endmodule

// File: rtl/icache_l1.sv
// icache_l1: direct-mapped read-only L1 icache, same-cycle hits, 128-bit line refill.
// Optional hit/miss counters enabled by defining ICACHE_PERF_CNT_EN.
module icache_l1
  import lc3b_types::*;
#(
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_read,
  input  lc3b_word      imem_address,
  output lc3b_word      imem_rdata,
  output logic          imem_resp,
  input  logic          inv_all,
  output logic          pmem_read,
  output lc3b_word      pmem_address,
  input  lc3b_cacheline pmem_rdata,
  input  logic          pmem_resp
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W = 12 - INDEX_W;
  icache_state_t state;
  lc3b_word miss_addr;
  logic discard, idle, hit, start, install, a_valid, unused;
  logic [INDEX_W-1:0] a_index;
  logic [TAG_W-1:0] a_tag;
  lc3b_cacheline a_line;
  // during FILL the array port addresses the set being refilled
  assign idle = state == IDLE;
  assign a_index = idle ? imem_address[4+:INDEX_W] : miss_addr[4+:INDEX_W];
  assign hit = a_valid && a_tag == imem_address[15-:TAG_W];
  assign imem_resp = rst_n && idle && imem_read && hit && !inv_all;
  assign start = idle && imem_read && !hit && !inv_all;
  assign install = rst_n && !idle && pmem_resp && !discard && !inv_all;
  assign imem_rdata = a_line[{imem_address[3:1], 4'b0}+:16];
  assign pmem_read = rst_n && !idle;
  assign pmem_address = miss_addr;
  assign unused = imem_address[0];
  icache_array #(.SETS(SETS)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .index(a_index),
    .we(install),
    .wtag(miss_addr[15-:TAG_W]),
    .wline(pmem_rdata),
    .inv_all(inv_all),
    .valid(a_valid),
    .tag(a_tag),
    .line(a_line)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      miss_addr <= '0;
      discard <= 1'b0;
    end else if (idle) begin
      if (start) begin
        state <= FILL;
        miss_addr <= {imem_address[15:4], 4'b0};
      end
    end else if (pmem_resp) begin
      state <= IDLE;
      discard <= 1'b0;
    end else if (inv_all) discard <= 1'b1;
  end
`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (imem_resp) hit_count <= hit_count + 16'd1;
      if (start) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_l1.sv
// tb_icache_l1: random and directed fetch traffic checked against a line-level cache model.
module tb_icache_l1;
  logic clk = 1'b0;
  logic rst_n, imem_read, inv_all, pmem_read, pmem_resp, imem_resp;
  logic [15:0] imem_address, imem_rdata, pmem_address;
  logic [127:0] pmem_rdata;
  int checks = 0, errors = 0;
  logic m_idle = 1'b1, m_disc = 1'b0;
  logic [7:0] m_valid = '0;
  logic [11:0] m_tag [8];
  logic [15:0] m_addr = '0;
  int cnt = 0;
  int m_hits = 0, m_misses = 0;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
`endif
  always #5 clk = ~clk;
  icache_l1 dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_read(imem_read),
    .imem_address(imem_address),
    .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .inv_all(inv_all),
    .pmem_read(pmem_read),
    .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16+:16] = a ^ 16'(w * 16'h1357) ^ 16'h5a5a;
    return l;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rst, input logic rd, input logic [15:0] a, input logic inv, input logic stray);
    logic hit, eresp;
    logic [127:0] l;
    logic [2:0] idx;
    @(negedge clk);
    rst_n = ~rst;
    imem_read = rd;
    imem_address = a;
    inv_all = inv;
    pmem_resp = (!m_idle && cnt == 0) || (m_idle && stray);
    pmem_rdata = mem_line(m_addr);
    #1;
    idx = a[6:4];
    hit = m_valid[idx] && m_tag[idx] == a[15:4];
    eresp = !rst && m_idle && rd && !inv && hit;
    check("imem_resp", 32'(imem_resp), 32'(eresp));
    if (eresp) begin
      l = mem_line({a[15:4], 4'h0}) >> (a[3:1] * 16);
      check("imem_rdata", 32'(imem_rdata), 32'(l[15:0]));
    end
    check("pmem_read", 32'(pmem_read), 32'(!rst && !m_idle));
    check("pmem_address", 32'(pmem_address), 32'(m_addr));
`ifdef ICACHE_PERF_CNT_EN
    check("hit_count", 32'(hit_count), 32'(m_hits[15:0]));
    check("miss_count", 32'(miss_count), 32'(m_misses[15:0]));
`endif
    if (rst) begin
      m_valid = '0;
      m_idle = 1'b1;
      m_disc = 1'b0;
      m_addr = '0;
      m_hits = 0;
      m_misses = 0;
    end else if (m_idle) begin
      if (eresp) m_hits++;
      if (inv) m_valid = '0;
      else if (rd && !hit) begin
        m_idle = 1'b0;
        m_disc = 1'b0;
        m_addr = {a[15:4], 4'h0};
        cnt = $urandom_range(0, 3);
        m_misses++;
      end
    end else begin
      if (inv) begin
        m_valid = '0;
        m_disc = 1'b1;
      end
      if (pmem_resp) begin
        if (!m_disc) begin
          m_valid[m_addr[6:4]] = 1'b1;
          m_tag[m_addr[6:4]] = m_addr[15:4];
        end
        m_idle = 1'b1;
      end else cnt--;
    end
  endtask
  initial begin
    logic [15:0] a;
    rst_n = 1'b0;
    imem_read = 1'b0;
    imem_address = '0;
    inv_all = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    repeat (2) step(1, 1, 16'h3002, 0, 0);
    repeat (8) step(0, 1, 16'h3002, 0, 0);
    step(0, 1, 16'h300e, 0, 0);
    repeat (8) step(0, 1, 16'h3080, 0, 0);
    repeat (8) step(0, 1, 16'h3000, 0, 0);
    step(0, 1, 16'h4000, 0, 0);
    repeat (8) step(0, 1, 16'h3004, 0, 0);
    step(0, 1, 16'h4000, 0, 0);
    step(0, 1, 16'h5000, 0, 0);
    step(0, 1, 16'h5000, 1, 0);
    repeat (8) step(0, 1, 16'h5000, 0, 1);
    step(0, 1, 16'h4000, 0, 0);
    step(0, 1, 16'h6000, 0, 0);
    step(1, 1, 16'h6000, 0, 0);
    repeat (3) step(0, 0, 16'h6000, 0, 1);
    repeat (8) step(0, 1, 16'h3002, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      a = 16'h3000 + 16'($urandom_range(0, 3) << 7) + 16'($urandom_range(0, 7) << 4) + 16'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 4) != 0, a, $urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_l1.md
Name: icache_l1

Overview:
- Direct-mapped, read-only L1 instruction cache. It is the responder on the imem_* fetch interface.
- Serves 16-bit instruction words to the fetch stage with a same-cycle hit response.
- Refills 128-bit lines from the physical-memory side (pmem_*) on a miss.
- Sits between the fetch stage and the memory arbiter/L2.

Parameters:
- SETS, 8, number of lines. Power of two, 2..64. INDEX_W = log2(SETS). TAG_W = 12 - INDEX_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- imem_read  in  1  fetch request valid
- imem_address  in  16  byte address of instruction; bit 0 ignored
- imem_rdata  out  16  instruction word, valid when imem_resp=1
- imem_resp  out  1  request satisfied this cycle
- inv_all  in  1  invalidate all lines (self-modifying code / flush)
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_address  out  16  line-aligned fill address; bits [3:0]=0
- pmem_rdata  in  128  fill line; word w is at bits [16w+15:16w]
- pmem_resp  in  1  fill data valid, single-cycle pulse

Behaviour:
- Address split:
  - offset = imem_address[3:0], word select = [3:1]
  - index = [4+INDEX_W-1:4]
  - tag = [15:4+INDEX_W]
- Storage per set: valid bit, tag, 128-bit line, all in flops. Reads are combinational.
- hit = valid[index] & (tag_store[index] == tag).
- imem_resp = imem_read & hit & (state==IDLE) & rst_n. This is combinational, so hit latency is 0 cycles.
- imem_rdata = selected word of line[index], combinational. Don't-care when imem_resp=0. Implementation drives the array word.
- FSM has two states, IDLE and FILL.
- IDLE:
  - If imem_read & ~hit & ~inv_all: latch miss_addr = {imem_address[15:4],4'b0} and go to FILL.
  - Otherwise stay in IDLE.
- FILL:
  - pmem_read=1 and pmem_address=miss_addr, both stable throughout FILL.
  - On pmem_resp: write line, tag, valid=1 at miss_addr's index, unless discarded (see inv_all). Go to IDLE.
  - The next cycle re-evaluates the current imem_address, so miss-to-resp latency = pmem latency + 1 cycle.
  - imem_resp=0 throughout FILL.
- pmem_read=0 in IDLE. pmem_address=miss_addr always; 0 after reset.
- Requester contract: imem_address may change, and imem_read may drop, at any time (fetch redirect/stall). The cache never aborts an issued fill.
  - The fill completes and installs using the latched miss_addr.
  - The new address is evaluated in IDLE afterwards and may miss again.
- inv_all:
  - In IDLE: all valid bits clear at that edge. imem_resp is forced 0 that cycle and no miss is started.
  - In FILL: valid bits clear and a sticky discard flag sets. At pmem_resp the line is not installed (valid stays 0). Flag clears on return to IDLE.
  - inv_all coincident with pmem_resp: line discarded.
- Reset (rst_n=0 at edge):
  - All valid bits 0, state IDLE, discard flag 0, miss_addr 0.
  - pmem_read and imem_resp are 0 while rst_n=0.
  - Tag and data arrays are not reset.
  - Reset mid-FILL abandons the fill. The memory side must tolerate a dropped pmem_read.
- pmem_resp seen in IDLE is ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on every cycle with imem_resp=1.
  - miss_count increments on every IDLE->FILL transition.
  - Both wrap modulo 2^16 and are cleared by rst_n only, not by inv_all.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- lc3b_types package gains:
  - lc3b_cacheline (logic [127:0])
  - lc3b_word reused for addresses and instructions
  - the icache_state_t enum {IDLE, FILL}
- Sub-module icache_array holds valid/tag/data.
  - Inputs: index, write enable, write tag, write line, invalidate-all, synchronous active-low reset.
  - Combinational read of valid/tag/line.
- icache_l1 holds the FSM, miss_addr, discard flag, hit compare, word select and optional counters.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imem_read=1, addr 0x3002. pmem returns line with word1=0x1234 after 3 cycles.
  - Response: pmem_read=1 with pmem_address=0x3000 for 3 cycles; imem_resp=1 with rdata 0x1234 on the cycle after pmem_resp.
- Hits:
  - Stimulus: then addr 0x300E with imem_read=1.
  - Response: imem_resp=1 the same cycle, rdata = word7, no pmem_read.
- Conflict:
  - Stimulus: SETS=8, addr 0x3080 (same index 0, different tag).
  - Response: miss, fill from 0x3080; afterwards addr 0x3000 misses again.
- Redirect mid-fill:
  - Stimulus: miss on 0x4000; imem_address changes to 0x3004 during FILL.
  - Response: pmem_address stays 0x4000; line 0x4000 installed; after return to IDLE, 0x3004 is serviced (hit if resident).
- Invalidate:
  - Stimulus: inv_all during FILL for 0x5000.
  - Response: fill completes but 0x5000 then misses again; all previously resident lines miss.
- Reset mid-fill and counters:
  - Stimulus: rst_n=0 during FILL; with ICACHE_PERF_CNT_EN, run 1 miss then 5 hits.
  - Response: reset gives pmem_read=0, all lines invalid, counters 0. The run gives miss_count=1, hit_count=6 (5 plus the post-fill response).
